// File: rtl/dff_pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipeline_pkg
// Brief    : Shared defaults, count-width helper and stage record type.
// Revision : 1.0
// ============================================================================
package dff_pipeline_pkg;

    localparam int c_default_width = 8;
    localparam int c_default_depth = 3;

    // One stage as seen at default width: valid flag above the data word.
    typedef struct packed {
        logic                       valid;
        logic [c_default_width-1:0] data;
    } stage_rec_t;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipe_stage
// Brief    : One elastic register slot (valid + data) with load enable.
// Revision : 1.0
// ============================================================================
module dff_pipe_stage
    import dff_pipeline_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Data only moves with a valid word, so bubbles keep the last payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/dff_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : dff_pipeline
// Brief    : WIDTH x DEPTH elastic register pipeline with q/qbar and count.
//            Optional synchronous flush port under DFF_PIPELINE_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module dff_pipeline
    import dff_pipeline_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter int               DEPTH     = c_default_depth,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
`ifdef DFF_PIPELINE_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              d,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              q,
    output logic [WIDTH-1:0]              qbar,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int c_cnt_w = count_width(DEPTH);

    logic [DEPTH-1:0] w_load;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_up_valid;
    logic [WIDTH-1:0] w_data    [DEPTH];
    logic [WIDTH-1:0] w_up_data [DEPTH];
    logic             w_flush;
    logic             w_accept;
    logic             w_emit;
    logic [c_cnt_w-1:0] r_count;

`ifdef DFF_PIPELINE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // A stage may load when it is empty or its downstream neighbour loads.
    always_comb begin
        w_load = '0;
        w_load[DEPTH-1] = ~w_valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_load[i] = ~w_valid[i] | w_load[i+1];
        end
    end

    always_comb begin
        w_up_valid    = '0;
        w_up_valid[0] = in_valid;
        w_up_data[0]  = d;
        for (int i = 1; i < DEPTH; i++) begin
            w_up_valid[i] = w_valid[i-1];
            w_up_data[i]  = w_data[i-1];
        end
    end

    // Flush is folded in as a forced load of an invalid word: valids clear, data holds.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .i_load  (w_load[i] | w_flush),
            .i_valid (w_up_valid[i] & ~w_flush),
            .i_data  (w_up_data[i]),
            .o_valid (w_valid[i]),
            .o_data  (w_data[i])
        );
    end

    assign in_ready  = w_load[0] & ~w_flush;
    assign out_valid = w_valid[DEPTH-1] & ~w_flush;
    assign q         = w_data[DEPTH-1];
    assign qbar      = ~w_data[DEPTH-1];

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cnt_w'(w_accept) - c_cnt_w'(w_emit);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_dff_pipeline.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_pipeline
// Brief    : Scoreboard bench for dff_pipeline (8x3 and 1x1 instances).
// Revision : 1.0
// ============================================================================
module tb_dff_pipeline;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] d;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [7:0] q, qbar;
    logic [1:0] count;
`ifdef DFF_PIPELINE_FLUSH_EN
    logic       flush;
`endif

    logic [0:0] d1, q1, qbar1, count1;
    logic       in_valid1, in_ready1, out_valid1, out_ready1;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] sb  [$];
    logic [0:0] sb1 [$];

    dff_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_dut (
`ifdef DFF_PIPELINE_FLUSH_EN
        .flush     (flush),
`endif
        .clk       (clk),
        .reset     (reset),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .qbar      (qbar),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut1 (
`ifdef DFF_PIPELINE_FLUSH_EN
        .flush     (1'b0),
`endif
        .clk       (clk),
        .reset     (reset),
        .d         (d1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .q         (q1),
        .qbar      (qbar1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .count     (count1)
    );

    // Scoreboards: push on accepted handshakes, pop and compare on emits.
    always @(negedge clk) begin : mon8
        logic [7:0] e8;
        if (!reset) begin
            if (out_valid && out_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL sb8_emit: got q=%h, expected no word", q);
                end else begin
                    e8 = sb.pop_front();
                    if (q !== e8 || qbar !== ~e8) begin
                        fails++;
                        $display("FAIL sb8_data: got q=%h qbar=%h, expected q=%h qbar=%h", q, qbar, e8, ~e8);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(d);
        end
    end

    always @(negedge clk) begin : mon1
        logic [0:0] e1;
        if (!reset) begin
            if (out_valid1 && out_ready1) begin
                tests_run++;
                if (sb1.size() == 0) begin
                    fails++;
                    $display("FAIL sb1_emit: got q=%b, expected no word", q1);
                end else begin
                    e1 = sb1.pop_front();
                    if (q1 !== e1 || qbar1 !== ~e1) begin
                        fails++;
                        $display("FAIL sb1_data: got q=%b qbar=%b, expected q=%b qbar=%b", q1, qbar1, e1, ~e1);
                    end
                end
            end
            if (in_valid1 && in_ready1) sb1.push_back(d1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; d = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        d1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
`ifdef DFF_PIPELINE_FLUSH_EN
        flush = 1'b0;
`endif
        tick(); tick();
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0 || q !== 8'h00 || qbar !== 8'hFF) begin
            fails++;
            $display("FAIL reset_state: got ov=%b cnt=%0d q=%h qbar=%h, expected 0 0 00 ff", out_valid, count, q, qbar);
        end
        tests_run++;
        if (out_valid1 !== 1'b0 || count1 !== 1'b0 || q1 !== 1'b0 || qbar1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_state1: got ov=%b cnt=%0d q=%b qbar=%b, expected 0 0 0 1", out_valid1, count1, q1, qbar1);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b/%b, expected 1/1", in_ready, in_ready1);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_q [6] = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
        int         exp_c [6] = '{1, 2, 3, 2, 1, 0};
        logic [5:0] exp_ov = 6'b011100;
        out_ready = 1'b1; in_valid = 1'b1; d = 8'h01;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (out_valid !== exp_ov[k] || count !== 2'(exp_c[k])) begin
                fails++;
                $display("FAIL stream_c%0d: got ov=%b cnt=%0d, expected ov=%b cnt=%0d", k, out_valid, count, exp_ov[k], exp_c[k]);
            end
            if (exp_ov[k]) begin
                tests_run++;
                if (q !== exp_q[k] || qbar !== ~exp_q[k]) begin
                    fails++;
                    $display("FAIL stream_q%0d: got q=%h qbar=%h, expected q=%h qbar=%h", k, q, qbar, exp_q[k], ~exp_q[k]);
                end
            end
            in_valid = (k < 2);
            d = 8'(k + 2);
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0; in_valid = 1'b1; d = 8'hA1;
        tick(); d = 8'hA2;
        tick(); d = 8'hA3;
        tick(); d = 8'hA4;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || count !== 2'd3 || out_valid !== 1'b1 || q !== 8'hA1) begin
            fails++;
            $display("FAIL bp_full: got rdy=%b cnt=%0d ov=%b q=%h, expected 0 3 1 a1", in_ready, count, out_valid, q);
        end
        tick();
        tests_run++;
        if (in_ready !== 1'b0 || count !== 2'd3 || q !== 8'hA1) begin
            fails++;
            $display("FAIL bp_hold: got rdy=%b cnt=%0d q=%h, expected 0 3 a1", in_ready, count, q);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_passthru_rdy: got %b, expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (count !== 2'd3 || q !== 8'hA2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL bp_swap: got cnt=%0d q=%h ov=%b, expected 3 a2 1", count, q, out_valid);
        end
        n = 0;
        while ((out_valid || count != 0) && n < 20) begin
            tick();
            n++;
        end
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0 || n != 3) begin
            fails++;
            $display("FAIL bp_drain: got ov=%b cnt=%0d cycles=%0d, expected 0 0 3", out_valid, count, n);
        end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0; in_valid = 1'b1; d = 8'h55;
        tick(); in_valid = 1'b0;
        tick();
        tick(); in_valid = 1'b1; d = 8'hAA;
        tick(); in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (count !== 2'd2 || out_valid !== 1'b1 || q !== 8'h55 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bubble_hold: got cnt=%0d ov=%b q=%h rdy=%b, expected 2 1 55 1", count, out_valid, q, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || q !== 8'hAA || count !== 2'd1) begin
            fails++;
            $display("FAIL bubble_b2b: got ov=%b q=%h cnt=%0d, expected 1 aa 1", out_valid, q, count);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL bubble_empty: got ov=%b cnt=%0d, expected 0 0", out_valid, count);
        end
    endtask

    task automatic test_depth1();
        logic [0:0] exp_q [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [0:0] exp_v;
        out_ready1 = 1'b1; in_valid1 = 1'b1; d1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp_v = (k % 2 == 0) ? 1'b1 : 1'b0;
            tests_run++;
            if (out_valid1 !== exp_v || count1 !== exp_v || q1 !== exp_q[k] || qbar1 !== ~exp_q[k]) begin
                fails++;
                $display("FAIL d1_c%0d: got ov=%b cnt=%0d q=%b qbar=%b, expected %b %0d %b %b",
                         k, out_valid1, count1, q1, qbar1, exp_v, exp_v, exp_q[k], ~exp_q[k]);
            end
            in_valid1 = ((k + 1) % 2 == 0);
            d1 = (k + 1 == 2) ? 1'b0 : 1'b1;
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1; in_valid = 1'b1; d = 8'h11;
        tick(); d = 8'h22;
        tick(); in_valid = 1'b0;
        tests_run++;
        if (count !== 2'd2) begin
            fails++;
            $display("FAIL rst_inflight: got cnt=%0d, expected 2", count);
        end
        #1;
        reset = 1'b1;
        sb.delete();
        sb1.delete();
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0 || q !== 8'h00 || qbar !== 8'hFF) begin
            fails++;
            $display("FAIL rst_async: got ov=%b cnt=%0d q=%h qbar=%h, expected 0 0 00 ff", out_valid, count, q, qbar);
        end
        tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || count !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_release: got rdy=%b cnt=%0d ov=%b, expected 1 0 0", in_ready, count, out_valid);
        end
    endtask

`ifdef DFF_PIPELINE_FLUSH_EN
    task automatic test_flush();
        int lat;
        out_ready = 1'b0; in_valid = 1'b1; d = 8'hC1;
        tick(); d = 8'hC2;
        tick(); d = 8'hC3;
        tick(); d = 8'h99;
        flush = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_force: got rdy=%b ov=%b, expected 0 0", in_ready, out_valid);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        #1;
        tests_run++;
        if (count !== 2'd0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_clear: got cnt=%0d ov=%b, expected 0 0", count, out_valid);
        end
        out_ready = 1'b1; in_valid = 1'b1; d = 8'h3C;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != 2 || q !== 8'h3C) begin
            fails++;
            $display("FAIL flush_next: got latency=%0d q=%h, expected 2 3c", lat, q);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || count !== 2'd0) begin
            fails++;
            $display("FAIL flush_drain: got ov=%b cnt=%0d, expected 0 0", out_valid, count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_depth1();
        test_reset_midstream();
`ifdef DFF_PIPELINE_FLUSH_EN
        test_flush();
`endif
        tick();
        tick();
        tests_run++;
        if (sb.size() != 0 || sb1.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d/%0d words pending, expected 0/0", sb.size(), sb1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
